xbar_2x2_dispatch: RTL
======================

# xbar_2x2_dispatch

Upstream dispatch stage for the 2x2 4-bit crossbar. It buffers two independent input streams, each carrying a 4-bit payload and a 1-bit destination. Every cycle it resolves output-port contention with a round-robin arbiter, then drives the crossbar's two data inputs and its `control` select from registers. The crossbar is purely combinational, so this block fully determines what appears on crossbar `out1`/`out2` and when.

## Interface
- `FIFO_DEPTH`, 4: entries per input FIFO; power of two, ≥ 2.

- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `in1_valid`  input  1  stream 1 offers an item
- `in1_ready`  output  1  stream 1 FIFO can accept
- `in1_data`  input  4  stream 1 payload
- `in1_dest`  input  1  stream 1 destination: 0 = crossbar out1, 1 = crossbar out2
- `in2_valid`, `in2_ready`, `in2_data[3:0]`, `in2_dest`: same as stream 1, for stream 2
- `xb_in1`  output  4  drives crossbar `in1`, registered
- `xb_in2`  output  4  drives crossbar `in2`, registered
- `xb_control`  output  1  drives crossbar `control` (0 = straight, 1 = cross), registered
- `out1_valid`  output  1  crossbar `out1` carries a dispatched item this cycle
- `out2_valid`  output  1  crossbar `out2` carries a dispatched item this cycle

## Operation
- Each stream has a FIFO of `FIFO_DEPTH` × 5 bits ({dest, data}), with its own occupancy count.
- Push occurs when `inX_valid && inX_ready` at a rising edge.
- `inX_ready = !rst && count < FIFO_DEPTH`. When the FIFO is full, no push is accepted, even if a pop happens in the same cycle.
- Arbitration uses the heads (h1, h2) and dests (d1, d2) as they stood before the edge. Every rule below takes effect at that edge.
  - Neither head valid:
    - `out1_valid = out2_valid = 0`, `xb_in1 = xb_in2 = 0`, `xb_control = 0`.
  - Only h1 valid:
    - pop stream 1; `xb_in1 = h1.data`, `xb_in2 = 0`, `xb_control = d1`.
    - assert the valid for output d1.
  - Only h2 valid:
    - pop stream 2; `xb_in2 = h2.data`, `xb_in1 = 0`, `xb_control = !d2`.
    - assert the valid for output d2.
  - Both valid, d1 ≠ d2:
    - pop both; `xb_in1 = h1.data`, `xb_in2 = h2.data`, `xb_control = d1`.
    - both valids = 1.
    - `prio` unchanged.
  - Both valid, d1 = d2 (conflict):
    - the winner is stream 1 if `prio == 0`, otherwise stream 2. Pop only the winner and drive it as in the single-valid case; the loser's lane is 0.
    - `prio` toggles to favour the loser.
    - The loser's head stays in place and is re-arbitrated next cycle.
- `prio` is a 1-bit register that changes only on conflicts.
- Push and pop on the same FIFO in the same cycle are both performed, and the count is unchanged.
- A lane not carrying a dispatched item is always driven to 4'h0. The unused crossbar output may therefore show 0, and downstream must qualify with `outX_valid`.
- FIFO pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values (asserted at the edge with `rst = 1`):
  - all FIFOs empty, `prio = 0`;
  - `xb_in1 = xb_in2 = 0`, `xb_control = 0`, `out1_valid = out2_valid = 0`;
  - `in1_ready = in2_ready = 0` while `rst` is high.
- Reset mid-operation discards all queued items. There is no partial output, and the first post-reset conflict goes to stream 1.
- Latency: an item pushed into an empty FIFO at edge N is dispatched at edge N+1, so outputs are valid during cycle N+1.
- Throughput: 2 items/cycle when destinations differ, 1 item/cycle under conflict.
- No downstream backpressure: the consumer accepts every valid output every cycle.
- `inX_ready` is combinational from the count register only, with no path from `inX_valid`.

## Test plan
1. Hold `rst` for 2 cycles with both valids high → all outputs 0 and both readys 0. One cycle after release, readys = 1 and nothing is dispatched from pre-reset stimulus.
2. Push in1 = 4'hA, dest 0 and in2 = 4'h5, dest 1 at edge N → at edge N+1: `xb_in1 = A`, `xb_in2 = 5`, `xb_control = 0`, `out1_valid = out2_valid = 1`.
3. Push in1 = 4'h3, dest 1 and in2 = 4'hC, dest 0 → next edge: `xb_control = 1`, both valids 1, crossbar out1 = C, out2 = 3.
4. Both streams push dest 0 every cycle with in1 = 1, 2, 3… and in2 = 9, A, B…:
   - out1 sequence is 1, 9, 2, A, 3, B…;
   - `out2_valid` stays 0; `xb_control` alternates 0/1.
5. Continue scenario 4 for 10 cycles → both FIFOs reach `FIFO_DEPTH` and the readys drop. Once drained, every accepted item appears exactly once, in per-stream order, with no duplicates.
6. Assert `rst` with both FIFOs holding 3 items → next cycle all outputs 0 and no stale item ever appears. A new conflict then goes to stream 1 first.

Source files
------------

// File: rtl/xbar_2x2_dispatch_if.sv
// Handshake and crossbar-drive bundle for the 2x2 dispatch stage.
// The stream source (master) offers items and sees ready; the dispatch stage
// (slave) accepts items and drives the crossbar inputs, control and valids.
interface xbar_2x2_dispatch_if;
    logic       in1_valid;
    logic       in1_ready;
    logic [3:0] in1_data;
    logic       in1_dest;
    logic       in2_valid;
    logic       in2_ready;
    logic [3:0] in2_data;
    logic       in2_dest;
    logic [3:0] xb_in1;
    logic [3:0] xb_in2;
    logic       xb_control;
    logic       out1_valid;
    logic       out2_valid;

    modport master (
        output in1_valid, in1_data, in1_dest,
        output in2_valid, in2_data, in2_dest,
        input  in1_ready, in2_ready,
        input  xb_in1, xb_in2, xb_control, out1_valid, out2_valid
    );

    modport slave (
        input  in1_valid, in1_data, in1_dest,
        input  in2_valid, in2_data, in2_dest,
        output in1_ready, in2_ready,
        output xb_in1, xb_in2, xb_control, out1_valid, out2_valid
    );
endinterface

// File: rtl/xbar_2x2_dispatch.sv
// Dispatch stage for a 2x2 4-bit crossbar: two input FIFOs, round-robin
// resolution of output-port conflicts, registered crossbar drive.
module xbar_2x2_dispatch #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    xbar_2x2_dispatch_if.slave    bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Per-stream views of the interface so both FIFOs come from one generate loop.
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [1:0] in_dest;
    logic [3:0] in_data [2];
    logic [1:0] head_valid;
    logic [1:0] head_dest;
    logic [3:0] head_data [2];
    logic [1:0] pop;

    assign in_valid   = {bus.in2_valid, bus.in1_valid};
    assign in_dest    = {bus.in2_dest, bus.in1_dest};
    assign in_data[0] = bus.in1_data;
    assign in_data[1] = bus.in2_data;
    assign bus.in1_ready = in_ready[0];
    assign bus.in2_ready = in_ready[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [4:0]    mem [FIFO_DEPTH];
            logic [PW-1:0] wr_ptr_reg;
            logic [PW-1:0] rd_ptr_reg;
            logic [CW-1:0] count_reg;
            logic          push;

            // Ready looks only at the stored count, so a full FIFO refuses
            // a push even when the head is leaving on the same edge.
            assign in_ready[gi]   = !rst && (count_reg < CW'(FIFO_DEPTH));
            assign push           = in_valid[gi] && in_ready[gi];
            assign head_valid[gi] = (count_reg != '0);
            assign head_dest[gi]  = mem[rd_ptr_reg][4];
            assign head_data[gi]  = mem[rd_ptr_reg][3:0];

            // Storage write; contents need no reset because count gates use.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= {in_dest[gi], in_data[gi]};
                end
            end

            // Pointer and occupancy update; pointers wrap naturally at the depth.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    case ({push, pop[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    logic       prio_reg;
    logic       prio_next;
    logic [3:0] xb_in1_reg, xb_in1_next;
    logic [3:0] xb_in2_reg, xb_in2_next;
    logic       xb_control_reg, xb_control_next;
    logic       out1_valid_reg, out1_valid_next;
    logic       out2_valid_reg, out2_valid_next;

    // Arbitration: decide which heads leave this edge and how the crossbar is set.
    always_comb begin
        pop             = 2'b00;
        prio_next       = prio_reg;
        xb_in1_next     = 4'h0;
        xb_in2_next     = 4'h0;
        xb_control_next = 1'b0;
        out1_valid_next = 1'b0;
        out2_valid_next = 1'b0;

        if (head_valid == 2'b11 && head_dest[0] == head_dest[1]) begin
            // Both want the same output: grant the favoured stream, then favour the other.
            pop       = prio_reg ? 2'b10 : 2'b01;
            prio_next = !prio_reg;
        end else begin
            pop = head_valid;
        end

        if (pop[0]) begin
            xb_in1_next     = head_data[0];
            xb_control_next = head_dest[0];
            if (head_dest[0]) begin
                out2_valid_next = 1'b1;
            end else begin
                out1_valid_next = 1'b1;
            end
        end
        if (pop[1]) begin
            xb_in2_next = head_data[1];
            // When both leave, dests differ and stream 1 already fixed control.
            if (!pop[0]) begin
                xb_control_next = !head_dest[1];
            end
            if (head_dest[1]) begin
                out2_valid_next = 1'b1;
            end else begin
                out1_valid_next = 1'b1;
            end
        end
    end

    // Output and priority registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg       <= 1'b0;
            xb_in1_reg     <= 4'h0;
            xb_in2_reg     <= 4'h0;
            xb_control_reg <= 1'b0;
            out1_valid_reg <= 1'b0;
            out2_valid_reg <= 1'b0;
        end else begin
            prio_reg       <= prio_next;
            xb_in1_reg     <= xb_in1_next;
            xb_in2_reg     <= xb_in2_next;
            xb_control_reg <= xb_control_next;
            out1_valid_reg <= out1_valid_next;
            out2_valid_reg <= out2_valid_next;
        end
    end

    assign bus.xb_in1     = xb_in1_reg;
    assign bus.xb_in2     = xb_in2_reg;
    assign bus.xb_control = xb_control_reg;
    assign bus.out1_valid = out1_valid_reg;
    assign bus.out2_valid = out2_valid_reg;
endmodule
